// File: rtl/obstacle_monitor.sv
// obstacle_monitor: moving-average filter of sonar distance with hysteretic clear/warn/stop zones
// and a watchdog that faults the sensor when accepted readings stop arriving.
module obstacle_monitor #(
    parameter int WIDTH          = 16,
    parameter int AVG_LOG2       = 2,
    parameter int WARN_MM        = 600,
    parameter int STOP_MM        = 250,
    parameter int HYST_MM        = 50,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] distance,
    input  logic             distance_valid,
    output logic [WIDTH-1:0] filtered_distance,
    output logic             filtered_valid,
    output logic             obstacle,
    output logic             stop,
    output logic             fault,
    output logic [2:0]       state
);
    localparam int WIN = 1 << AVG_LOG2;
    localparam int SW  = WIDTH + AVG_LOG2;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIDTH:0]    STOP_LO = (WIDTH+1)'(STOP_MM);
    localparam logic [WIDTH:0]    WARN_LO = (WIDTH+1)'(WARN_MM);
    localparam logic [WIDTH:0]    STOP_HI = (WIDTH+1)'(STOP_MM + HYST_MM);
    localparam logic [WIDTH:0]    WARN_HI = (WIDTH+1)'(WARN_MM + HYST_MM);
    localparam logic [TW-1:0]     T_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]     T_PRE   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AVG_LOG2:0] FULL    = (AVG_LOG2+1)'(WIN);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_CLEAR = 3'd1,
        S_WARN  = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    ring_q [WIN];
    logic [SW-1:0]       sum_q, sum_d;
    logic [AVG_LOG2-1:0] idx_q;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [TW-1:0]       wd_q, wd_d;
    logic [WIDTH-1:0]    filt_q;
    logic                pend_q, fv_q;
    logic                acc, expire;
    logic [WIDTH:0]      f_ext;

    always_comb begin
        acc    = distance_valid && (distance != '0);
        // an accepted sample on the expiry cycle pre-empts the fault
        expire = !acc && (wd_q == T_PRE);
        wd_d   = acc ? '0 : (wd_q == T_MAX ? wd_q : wd_q + TW'(1));
        sum_d  = sum_q - SW'(ring_q[idx_q]) + SW'(distance);
        fill_d = (fill_q == FULL) ? fill_q : fill_q + (AVG_LOG2+1)'(1);
        f_ext  = {1'b0, filt_q};
        state_d = state_q;
        if (expire)
            state_d = S_FAULT;
        else if (state_q == S_FAULT)
            state_d = acc ? S_INIT : S_FAULT;
        else if (fv_q)
            case (state_q)
                S_INIT, S_CLEAR: state_d = f_ext <= STOP_LO ? S_STOP :
                                           f_ext <= WARN_LO ? S_WARN : S_CLEAR;
                S_WARN:          state_d = f_ext <= STOP_LO ? S_STOP :
                                           f_ext >  WARN_HI ? S_CLEAR : S_WARN;
                S_STOP:          state_d = f_ext >  STOP_HI ? S_WARN : S_STOP;
                default:         state_d = state_q;
            endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            for (int i = 0; i < WIN; i++) ring_q[i] <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            wd_q    <= '0;
            filt_q  <= '0;
            pend_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (expire) begin
                for (int i = 0; i < WIN; i++) ring_q[i] <= '0;
                sum_q  <= '0;
                idx_q  <= '0;
                fill_q <= '0;
            end else if (acc) begin
                ring_q[idx_q] <= distance;
                sum_q  <= sum_d;
                idx_q  <= idx_q + AVG_LOG2'(1);
                fill_q <= fill_d;
            end
            pend_q <= acc && (fill_d == FULL);
            fv_q   <= pend_q;
            if (pend_q) filt_q <= sum_q[SW-1:AVG_LOG2];
        end
    end

    assign filtered_distance = filt_q;
    assign filtered_valid    = fv_q;
    assign state             = state_q;
    assign obstacle          = (state_q == S_WARN) || (state_q == S_STOP);
    assign stop              = (state_q == S_INIT) || (state_q == S_STOP) || (state_q == S_FAULT);
    assign fault             = (state_q == S_FAULT);
endmodule

// File: tb/tb_obstacle_monitor.sv
// tb_obstacle_monitor: directed vectors with hand-computed filter values, zone transitions and
// watchdog timing for obstacle_monitor (watchdog shortened to 1000 cycles).
module tb_obstacle_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] distance = '0;
    logic        distance_valid = 1'b0;
    logic [15:0] filtered_distance;
    logic        filtered_valid, obstacle, stop, fault;
    logic [2:0]  state;
    int          checks = 0;
    int          errors = 0;

    obstacle_monitor #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .distance(distance), .distance_valid(distance_valid),
        .filtered_distance(filtered_distance), .filtered_valid(filtered_valid),
        .obstacle(obstacle), .stop(stop), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_state(input int es);
        chk("state", int'(state), es);
        chk("obstacle", int'(obstacle), int'(es == 2 || es == 3));
        chk("stop", int'(stop), int'(es == 0 || es == 3 || es == 4));
        chk("fault", int'(fault), int'(es == 4));
    endtask

    // call at a negedge; returns at the negedge after edge N+2 (N = accepting edge) plus gap
    task automatic feed(input int d, input bit pulse, input int ef, input int es, input int gap);
        distance = 16'(d);
        distance_valid = 1'b1;
        @(negedge clk);
        distance_valid = 1'b0;
        @(negedge clk);
        chk("filtered_valid", int'(filtered_valid), int'(pulse));
        if (pulse) chk("filtered_distance", int'(filtered_distance), ef);
        @(negedge clk);
        chk_state(es);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // 1: prime with 400s, then reset asynchronously mid-run
        feed(400, 0, 0, 0, 20);
        feed(400, 0, 0, 0, 20);
        feed(400, 0, 0, 0, 20);
        feed(400, 1, 400, 2, 20);
        #2 reset = 1'b1;
        #1;
        chk_state(0);
        chk("reset filtered_distance", int'(filtered_distance), 0);
        chk("reset filtered_valid", int'(filtered_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        feed(1000, 0, 0, 0, 197);
        feed(1000, 0, 0, 0, 197);
        feed(1000, 0, 0, 0, 197);
        feed(1000, 1, 1000, 1, 20);
        // 2: falling into WARN
        feed(500, 1, 875, 1, 20);
        feed(500, 1, 750, 1, 20);
        feed(500, 1, 625, 1, 20);
        feed(500, 1, 500, 2, 20);
        // 3: STOP entry, STOP->WARN release, WARN->CLEAR release
        feed(200, 1, 425, 2, 20);
        feed(200, 1, 350, 2, 20);
        feed(200, 1, 275, 2, 20);
        feed(200, 1, 200, 3, 20);
        feed(320, 1, 230, 3, 20);
        feed(320, 1, 260, 3, 20);
        feed(320, 1, 290, 3, 20);
        feed(320, 1, 320, 2, 20);
        feed(700, 1, 415, 2, 20);
        feed(700, 1, 510, 2, 20);
        feed(700, 1, 605, 2, 20);
        feed(700, 1, 700, 1, 20);
        // 4: hysteresis hold in WARN
        feed(500, 1, 650, 1, 20);
        feed(500, 1, 600, 2, 20);
        feed(500, 1, 550, 2, 20);
        feed(500, 1, 500, 2, 20);
        feed(620, 1, 530, 2, 20);
        feed(620, 1, 560, 2, 20);
        feed(620, 1, 590, 2, 20);
        feed(620, 1, 620, 2, 20);
        feed(660, 1, 630, 2, 20);
        feed(660, 1, 640, 2, 20);
        feed(660, 1, 650, 2, 20);
        feed(660, 1, 660, 1, 0);
        // 5: watchdog expiry exactly 1000 cycles after the last accepted sample
        repeat (997) @(negedge clk);
        chk("state before expiry", int'(state), 1);
        @(negedge clk);
        chk_state(4);
        repeat (5) @(negedge clk);
        feed(800, 0, 0, 0, 20);
        chk("filtered hold", int'(filtered_distance), 660);
        feed(800, 0, 0, 0, 20);
        feed(800, 0, 0, 0, 20);
        feed(800, 1, 800, 1, 0);
        repeat (997) @(negedge clk);
        feed(800, 1, 800, 1, 0);
        // 6: zero readings neither update the filter nor feed the watchdog
        for (int i = 0; i < 9; i++) begin
            distance = '0;
            distance_valid = 1'b1;
            @(negedge clk);
            distance_valid = 1'b0;
            @(negedge clk);
            chk("zero no pulse", int'(filtered_valid), 0);
            repeat (98) @(negedge clk);
        end
        chk("zero filtered hold", int'(filtered_distance), 800);
        repeat (97) @(negedge clk);
        chk("state before zero expiry", int'(state), 1);
        @(negedge clk);
        chk_state(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
